// File: rtl/hvac_pkg.sv
// ---------------------------------------------------------------------------
// hvac_pkg
// Types and constants shared by the multi-zone HVAC controller.
//   state_t          : per-zone operating mode (IDLE / HEAT / COOL); code 3 is
//                      illegal and is steered back to IDLE by the zone FSM.
//   FAULT_CODE_LOW   : sensor code reported by a shorted / absent sensor.
//   fault_code_high  : all-ones sensor code for a given width (open sensor).
// ---------------------------------------------------------------------------
package hvac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAT = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  localparam int unsigned FAULT_CODE_LOW = 0;

  // All-ones code of width w, returned at 32 bits; callers truncate to w.
  function automatic logic [31:0] fault_code_high(input int unsigned w);
    logic [31:0] mask;
    if (w >= 32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << w) - 32'd1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/hvac_zone_fsm.sv
// ---------------------------------------------------------------------------
// hvac_zone_fsm
// One climate zone: IDLE/HEAT/COOL state register, minimum-dwell counter,
// registered sensor-fault flag and the threshold comparators.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   enable_i   in   global run enable
//   temp_i     in   TEMP_W  unsigned sensor code for this zone
//   heating_o  out  1 while the zone is in HEAT
//   cooling_o  out  1 while the zone is in COOL
//   fault_o    out  1 while the last sampled sensor code was invalid
// ---------------------------------------------------------------------------
module hvac_zone_fsm
  import hvac_pkg::*;
#(
  parameter int TEMP_W    = 5,
  parameter int HEAT_ON   = 18,
  parameter int TARGET    = 20,
  parameter int COOL_ON   = 22,
  parameter int MIN_DWELL = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic [TEMP_W-1:0] temp_i,
  output logic              heating_o,
  output logic              cooling_o,
  output logic              fault_o
);

  // A one-bit counter is kept even when MIN_DWELL=1; it then only ever holds 0.
  localparam int DWELL_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(MIN_DWELL - 1);

  localparam logic [TEMP_W-1:0] HEAT_ON_C   = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] TARGET_C    = TEMP_W'(TARGET);
  localparam logic [TEMP_W-1:0] COOL_ON_C   = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] CODE_LOW_C  = TEMP_W'(FAULT_CODE_LOW);
  localparam logic [TEMP_W-1:0] CODE_HIGH_C = TEMP_W'(fault_code_high(TEMP_W));

  state_t               state_q, state_d;
  state_t               goal;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   dwell_dec;
  logic                 fault_q, fault_d;

  logic code_bad;
  logic heat_req;
  logic cool_req;
  logic at_or_above_target;
  logic at_or_below_target;
  logic dwell_done;
  logic state_illegal;

  // Threshold compares, all unsigned at sensor width.
  always_comb begin
    code_bad           = (temp_i == CODE_LOW_C) || (temp_i == CODE_HIGH_C);
    heat_req           = (temp_i <= HEAT_ON_C);
    cool_req           = (temp_i >= COOL_ON_C);
    at_or_above_target = (temp_i >= TARGET_C);
    at_or_below_target = (temp_i <= TARGET_C);
    dwell_done         = (dwell_q == '0);
    dwell_dec          = dwell_done ? '0 : (dwell_q - DWELL_W'(1));
    state_illegal      = !((state_q == ST_IDLE) || (state_q == ST_HEAT) ||
                           (state_q == ST_COOL));
  end

  // Where the zone would like to be if nothing (dwell, fault, enable) held it.
  // HEAT and COOL only ever return to IDLE, so they are never adjacent.
  always_comb begin
    goal = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (heat_req) begin
          goal = ST_HEAT;
        end else if (cool_req) begin
          goal = ST_COOL;
        end
      end
      ST_HEAT: begin
        if (at_or_above_target) begin
          goal = ST_IDLE;
        end
      end
      ST_COOL: begin
        if (at_or_below_target) begin
          goal = ST_IDLE;
        end
      end
      default: goal = ST_IDLE;
    endcase
  end

  // Next-state: fault beats disable beats normal operation.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_dec;
    fault_d = 1'b0;
    if (code_bad) begin
      // Pinning the counter at its load value means the zone has to sit out
      // a full dwell after the sensor recovers.
      state_d = ST_IDLE;
      dwell_d = DWELL_LOAD;
      fault_d = 1'b1;
    end else if (!enable_i) begin
      // Cleared rather than loaded so re-enabling takes effect on the next edge.
      state_d = ST_IDLE;
      dwell_d = '0;
    end else if ((dwell_done || state_illegal) && (goal != state_q)) begin
      // An illegal code escapes without waiting for the dwell counter.
      state_d = goal;
      dwell_d = DWELL_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      fault_q <= fault_d;
    end
  end

  // Decoded straight from the state register: glitch-free, never both high.
  assign heating_o = (state_q == ST_HEAT);
  assign cooling_o = (state_q == ST_COOL);
  assign fault_o   = fault_q;

endmodule

// File: rtl/hvac_zone_ctrl.sv
// ---------------------------------------------------------------------------
// hvac_zone_ctrl
// Multi-zone heating/cooling controller: ZONES independent zone FSMs plus a
// count of zones currently driving an actuator.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   global run enable
//   temperature  in   ZONES*TEMP_W, zone z at [z*TEMP_W +: TEMP_W]
//   heating      out  ZONES, bit z high while zone z heats
//   cooling      out  ZONES, bit z high while zone z cools
//   fault        out  ZONES, bit z high while zone z's sensor code is invalid
//   active_cnt   out  $clog2(ZONES+1), zones in HEAT or COOL
// ---------------------------------------------------------------------------
module hvac_zone_ctrl
  import hvac_pkg::*;
#(
  parameter int ZONES     = 4,
  parameter int TEMP_W    = 5,
  parameter int HEAT_ON   = 18,
  parameter int TARGET    = 20,
  parameter int COOL_ON   = 22,
  parameter int MIN_DWELL = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [ZONES*TEMP_W-1:0]      temperature,
  output logic [ZONES-1:0]             heating,
  output logic [ZONES-1:0]             cooling,
  output logic [ZONES-1:0]             fault,
  output logic [$clog2(ZONES+1)-1:0]   active_cnt
);

  localparam int CNT_W = $clog2(ZONES + 1);

  logic [ZONES-1:0] zone_on;
  logic [CNT_W-1:0] active_sum;

  for (genvar gi = 0; gi < ZONES; gi++) begin : g_zone
    hvac_zone_fsm #(
      .TEMP_W    (TEMP_W),
      .HEAT_ON   (HEAT_ON),
      .TARGET    (TARGET),
      .COOL_ON   (COOL_ON),
      .MIN_DWELL (MIN_DWELL)
    ) u_zone (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable_i  (enable),
      .temp_i    (temperature[gi*TEMP_W +: TEMP_W]),
      .heating_o (heating[gi]),
      .cooling_o (cooling[gi]),
      .fault_o   (fault[gi])
    );
  end

  assign zone_on = heating | cooling;

  // Popcount of the registered zone outputs; follows the states with no delay.
  always_comb begin
    active_sum = '0;
    for (int z = 0; z < ZONES; z++) begin
      active_sum = active_sum + CNT_W'(zone_on[z]);
    end
  end

  assign active_cnt = active_sum;

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
module tb_hvac_zone_ctrl;

  localparam int ZONES     = 4;
  localparam int TEMP_W    = 5;
  localparam int HEAT_ON   = 18;
  localparam int TARGET    = 20;
  localparam int COOL_ON   = 22;
  localparam int MIN_DWELL = 8;
  localparam int CNT_W     = $clog2(ZONES + 1);
  localparam int CODE_MAX  = (1 << TEMP_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      enable = 1'b1;
  logic [ZONES*TEMP_W-1:0]   temperature;
  logic [ZONES-1:0]          heating;
  logic [ZONES-1:0]          cooling;
  logic [ZONES-1:0]          fault;
  logic [CNT_W-1:0]          active_cnt;

  int  checks = 0;
  int  passes = 0;
  bit  cmp_en = 1'b0;

  hvac_zone_ctrl #(
    .ZONES(ZONES), .TEMP_W(TEMP_W), .HEAT_ON(HEAT_ON), .TARGET(TARGET),
    .COOL_ON(COOL_ON), .MIN_DWELL(MIN_DWELL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .temperature(temperature),
    .heating(heating), .cooling(cooling), .fault(fault), .active_cnt(active_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
  endtask

  // Behavioural model: per zone a mode (0 idle, 1 heat, 2 cool) and the first
  // edge number at which a normal mode change is allowed again.
  int     md   [ZONES] = '{default: 0};
  longint rdy  [ZONES] = '{default: 0};
  bit     flt  [ZONES] = '{default: 0};
  longint n_edge = 0;

  always @(posedge clk or negedge rst_n) begin
    int t, nm;
    if (!rst_n) begin
      n_edge = 0;
      for (int z = 0; z < ZONES; z++) begin
        md[z] = 0; rdy[z] = 0; flt[z] = 1'b0;
      end
    end else begin
      n_edge++;
      for (int z = 0; z < ZONES; z++) begin
        t = int'(temperature[z*TEMP_W +: TEMP_W]);
        if (t == 0 || t == CODE_MAX) begin
          flt[z] = 1'b1; md[z] = 0; rdy[z] = n_edge + MIN_DWELL;
        end else begin
          flt[z] = 1'b0;
          if (!enable) begin
            md[z] = 0; rdy[z] = n_edge + 1;
          end else if (n_edge >= rdy[z]) begin
            nm = md[z];
            if (md[z] == 0) nm = (t <= HEAT_ON) ? 1 : (t >= COOL_ON) ? 2 : 0;
            else if (md[z] == 1 && t >= TARGET) nm = 0;
            else if (md[z] == 2 && t <= TARGET) nm = 0;
            if (nm != md[z]) begin
              md[z] = nm; rdy[z] = n_edge + MIN_DWELL;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    int eh, ec, ef, ea;
    if (cmp_en) begin
      eh = 0; ec = 0; ef = 0; ea = 0;
      for (int z = 0; z < ZONES; z++) begin
        if (md[z] == 1) eh |= (1 << z);
        if (md[z] == 2) ec |= (1 << z);
        if (flt[z])     ef |= (1 << z);
        if (md[z] != 0) ea++;
      end
      chk("model heating", int'(heating), eh);
      chk("model cooling", int'(cooling), ec);
      chk("model fault", int'(fault), ef);
      chk("model active_cnt", int'(active_cnt), ea);
      chk("heat/cool exclusive", int'(heating & cooling), 0);
    end
  end

  task automatic set_t(input int z, input int v);
    logic [TEMP_W-1:0] code;
    code = TEMP_W'(v);
    temperature[z*TEMP_W +: TEMP_W] = code;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int z = 0; z < ZONES; z++) set_t(z, 19);
    // 1: reset, then idle hold at t=19
    step(3);
    cmp_en = 1'b1;
    chk("reset heating", int'(heating), 0);
    chk("reset cooling", int'(cooling), 0);
    chk("reset fault", int'(fault), 0);
    chk("reset active_cnt", int'(active_cnt), 0);
    #2 rst_n = 1'b1;
    step(5);
    chk("idle hold heating", int'(heating), 0);
    chk("idle hold active_cnt", int'(active_cnt), 0);

    // 2: basic heat and cool cycle on zone 0
    set_t(0, 17); step(1);
    chk("z0 heat on", int'(heating[0]), 1);
    set_t(0, 19); step(3);
    chk("z0 heat at 19", int'(heating[0]), 1);
    set_t(0, 20); step(4);
    chk("z0 heat held by dwell", int'(heating[0]), 1);
    step(1);
    chk("z0 heat off at target", int'(heating[0]), 0);
    set_t(0, 23); step(7);
    chk("z0 cool waits dwell", int'(cooling[0]), 0);
    step(1);
    chk("z0 cool on", int'(cooling[0]), 1);
    set_t(0, 21); step(8);
    chk("z0 cool holds at 21", int'(cooling[0]), 1);
    set_t(0, 20); step(1);
    chk("z0 cool off at target", int'(cooling[0]), 0);

    // 3: dwell timing, heat at edge k, idle at k+8, cool at k+16
    set_t(0, 19); step(8);
    set_t(0, 17); step(1);
    chk("dwell heat at k", int'(heating[0]), 1);
    set_t(0, 25); step(1);
    chk("dwell heat at k+1", int'(heating[0]), 1);
    step(6);
    chk("dwell heat at k+7", int'(heating[0]), 1);
    step(1);
    chk("dwell idle at k+8", int'(heating[0] | cooling[0]), 0);
    step(7);
    chk("dwell no cool at k+15", int'(cooling[0]), 0);
    step(1);
    chk("dwell cool at k+16", int'(cooling[0]), 1);

    // 4: sensor fault on zone 1, zone 2 independent
    set_t(0, 20); set_t(1, 17); set_t(2, 23); step(1);
    chk("z1 heat", int'(heating[1]), 1);
    chk("z2 cool", int'(cooling[2]), 1);
    set_t(1, 31); step(1);
    chk("z1 fault forces idle", int'(heating[1]), 0);
    chk("z1 fault flag", int'(fault[1]), 1);
    chk("z2 unaffected", int'(cooling[2]), 1);
    step(2);
    chk("z1 fault persists", int'(fault[1]), 1);
    set_t(1, 15); step(1);
    chk("z1 fault clears", int'(fault[1]), 0);
    chk("z1 still idle", int'(heating[1]), 0);
    step(6);
    chk("z1 idle before dwell end", int'(heating[1]), 0);
    step(1);
    chk("z1 heat resumes", int'(heating[1]), 1);
    chk("z2 still cooling", int'(cooling[2]), 1);

    // 5: global enable
    set_t(0, 17); set_t(3, 25); step(10);
    chk("all active", int'(active_cnt), 4);
    enable = 1'b0; step(1);
    chk("disable active_cnt", int'(active_cnt), 0);
    chk("disable heating", int'(heating | cooling), 0);
    enable = 1'b1; step(1);
    chk("reenable active_cnt", int'(active_cnt), 4);
    chk("reenable heating", int'(heating), 4'b0011);
    chk("reenable cooling", int'(cooling), 4'b1100);

    // zero sensor code is also a fault
    set_t(3, 0); step(1);
    chk("z3 zero code fault", int'(fault[3]), 1);
    chk("z3 zero code idle", int'(cooling[3]), 0);
    set_t(3, 25); step(1);
    chk("z3 fault clear", int'(fault[3]), 0);

    // 6: asynchronous reset mid-dwell
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst heating", int'(heating), 0);
    chk("async rst cooling", int'(cooling), 0);
    chk("async rst active_cnt", int'(active_cnt), 0);
    for (int z = 0; z < ZONES; z++) set_t(z, 17);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("heat on first edge after reset", int'(heating), 4'b1111);
    chk("active after reset", int'(active_cnt), 4);

    step(2);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
